// File: rtl/gates_pkg.sv
// Shared types and golden model for the gates response checker.
package gates_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} chk_state_t;

    localparam int NUM_OUTS = 5;

    // Golden gate outputs for one bit position, bit k-1 corresponds to yk:
    // {NOR, NAND, XOR, OR, AND}. Applied per bit so the checker width stays free.
    function automatic logic [NUM_OUTS-1:0] gates_golden(input logic a, input logic b);
        return {~(a | b), ~(a & b), a ^ b, a | b, a & b};
    endfunction

endpackage

// File: rtl/gates_golden_stage.sv
// S1 of the checker pipeline: captures DUT results and computes the golden values.
module gates_golden_stage
    import gates_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_vld,
    input  logic [WIDTH-1:0]                   a,
    input  logic [WIDTH-1:0]                   b,
    input  logic [NUM_OUTS-1:0][WIDTH-1:0]     y,
    output logic                               vld,
    output logic [NUM_OUTS-1:0][WIDTH-1:0]     act,
    output logic [NUM_OUTS-1:0][WIDTH-1:0]     exp
);

    logic [WIDTH-1:0][NUM_OUTS-1:0] gold_bits;
    logic [NUM_OUTS-1:0][WIDTH-1:0] exp_d;

    // Golden model evaluated bit by bit, then transposed into per-output words.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign gold_bits[i] = gates_golden(a[i], b[i]);
        for (genvar k = 0; k < NUM_OUTS; k++) begin : g_out
            assign exp_d[k][i] = gold_bits[i][k];
        end
    end

    // Stage register; data only moves with a valid vector so idle cycles hold state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= 1'b0;
            act <= '0;
            exp <= '0;
        end else begin
            vld <= in_vld;
            if (in_vld) begin
                act <= y;
                exp <= exp_d;
            end
        end
    end

endmodule

// File: rtl/gates_checker.sv
// Streaming response checker: compares DUT gate results against a golden
// model and tallies pass/fail over a programmed run of vectors.
module gates_checker
    import gates_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [CNT_W-1:0]    num_vectors,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [WIDTH-1:0]    y1,
    input  logic [WIDTH-1:0]    y2,
    input  logic [WIDTH-1:0]    y3,
    input  logic [WIDTH-1:0]    y4,
    input  logic [WIDTH-1:0]    y5,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [CNT_W-1:0]    vec_count,
    output logic [CNT_W-1:0]    err_count,
    output logic [CNT_W-1:0]    first_fail_idx,
    output logic [4:0]          first_fail_mask
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    chk_state_t                     state;
    logic [CNT_W-1:0]               num_reg;
    logic [CNT_W-1:0]               acc_count;
    logic                           xfer;
    logic                           start_ok;
    logic [NUM_OUTS-1:0][WIDTH-1:0] y_vec;
    logic                           s1_vld;
    logic [NUM_OUTS-1:0][WIDTH-1:0] s1_act;
    logic [NUM_OUTS-1:0][WIDTH-1:0] s1_exp;
    logic [NUM_OUTS-1:0]            mask_d;
    logic                           s2_vld;
    logic [NUM_OUTS-1:0]            s2_mask;

    // Ready depends on registered state only, never on in_valid.
    assign in_ready = (state == RUN) && (acc_count < num_reg);
    assign xfer     = in_valid && in_ready;
    assign start_ok = start && ((state == IDLE) || (state == DONE));
    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == DONE);
    assign pass     = done && (err_count == '0);
    assign y_vec    = {y5, y4, y3, y2, y1};

    gates_golden_stage #(.WIDTH(WIDTH)) u_s1 (
        .clk    (clk),
        .reset  (reset),
        .in_vld (xfer),
        .a      (a),
        .b      (b),
        .y      (y_vec),
        .vld    (s1_vld),
        .act    (s1_act),
        .exp    (s1_exp)
    );

    // Any differing bit in an output word flags that output.
    for (genvar k = 0; k < NUM_OUTS; k++) begin : g_cmp
        assign mask_d[k] = |(s1_act[k] ^ s1_exp[k]);
    end

    // S2 register: per-vector mismatch mask, consumed by the counters next edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_vld  <= 1'b0;
            s2_mask <= '0;
        end else begin
            s2_vld  <= s1_vld;
            s2_mask <= mask_d;
        end
    end

    // Run FSM and result counters; an accepted start clears results on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            num_reg         <= '0;
            acc_count       <= '0;
            vec_count       <= '0;
            err_count       <= '0;
            first_fail_idx  <= '0;
            first_fail_mask <= '0;
        end else begin
            if (s2_vld) begin
                if (vec_count != CNT_MAX) vec_count <= vec_count + 1'b1;
                if (|s2_mask) begin
                    if (err_count == '0) begin
                        first_fail_idx  <= vec_count;
                        first_fail_mask <= s2_mask;
                    end
                    if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
                end
            end
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        num_reg         <= num_vectors;
                        acc_count       <= '0;
                        vec_count       <= '0;
                        err_count       <= '0;
                        first_fail_idx  <= '0;
                        first_fail_mask <= '0;
                        state           <= (num_vectors == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        acc_count <= acc_count + 1'b1;
                        if (acc_count + 1'b1 == num_reg) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The last vector leaves S2 on this edge once S1 is empty.
                    if (!s1_vld) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gates_checker.sv
// Directed, table-driven bench for gates_checker.
module tb_gates_checker;

    localparam int W = 4;
    localparam int C = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [C-1:0]  num_vectors = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0, b = '0;
    logic [W-1:0]  y1 = '0, y2 = '0, y3 = '0, y4 = '0, y5 = '0;
    logic          busy, done, pass;
    logic [C-1:0]  vec_count, err_count, first_fail_idx;
    logic [4:0]    first_fail_mask;

    gates_checker #(.WIDTH(W), .CNT_W(C)) dut (
        .clk(clk), .reset(reset), .start(start), .num_vectors(num_vectors),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5),
        .busy(busy), .done(done), .pass(pass), .vec_count(vec_count),
        .err_count(err_count), .first_fail_idx(first_fail_idx),
        .first_fail_mask(first_fail_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]      a;
        logic [W-1:0]      b;
        logic [4:0][W-1:0] y;         // y[k-1] = yk as driven
        logic [4:0]        exp_mask;  // hand-computed mismatch mask
    } vec_t;

    vec_t tbl [0:11];
    int   seq [$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [W-1:0] va, input logic [W-1:0] vb,
                           input logic [W-1:0] r1, input logic [W-1:0] r2, input logic [W-1:0] r3,
                           input logic [W-1:0] r4, input logic [W-1:0] r5, input logic [4:0] m);
        tbl[i].a = va;
        tbl[i].b = vb;
        tbl[i].y = {r5, r4, r3, r2, r1};
        tbl[i].exp_mask = m;
    endtask

    task automatic drive_vec(input int i);
        a  = tbl[i].a;
        b  = tbl[i].b;
        y1 = tbl[i].y[0];
        y2 = tbl[i].y[1];
        y3 = tbl[i].y[2];
        y4 = tbl[i].y[3];
        y5 = tbl[i].y[4];
    endtask

    // Called just after a rising edge; leaves the bench just after the next one.
    task automatic pulse_start(input logic [C-1:0] n);
        start = 1'b1;
        num_vectors = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Stream seq; optionally raise start (with a different length) alongside vector glitch.
    task automatic stream(input int glitch);
        int bound;
        foreach (seq[j]) begin
            drive_vec(seq[j]);
            in_valid = 1'b1;
            if (j == glitch) begin
                start = 1'b1;
                num_vectors = 2;
            end
            bound = 0;
            forever begin
                @(negedge clk);
                if (in_ready) break;
                bound++;
                if (bound > 20) begin
                    check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
                    in_valid = 1'b0;
                    start = 1'b0;
                    return;
                end
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int bound = 0;
        while (!done && bound < 50) begin
            @(negedge clk);
            bound++;
        end
        if (!done) check("done_timeout", {31'd0, done}, 32'd1);
    endtask

    // Expected results derived from the hand-written masks of the streamed vectors.
    task automatic check_run(input string name);
        int ee = 0;
        int fi = 0;
        logic [4:0] fm = '0;
        foreach (seq[j]) begin
            if (tbl[seq[j]].exp_mask != 5'd0) begin
                if (ee == 0) begin
                    fi = j;
                    fm = tbl[seq[j]].exp_mask;
                end
                ee++;
            end
        end
        check({name, "_done"},      {31'd0, done}, 32'd1);
        check({name, "_pass"},      {31'd0, pass}, (ee == 0) ? 32'd1 : 32'd0);
        check({name, "_busy"},      {31'd0, busy}, 32'd0);
        check({name, "_in_ready"},  {31'd0, in_ready}, 32'd0);
        check({name, "_vec_count"}, {16'd0, vec_count}, seq.size());
        check({name, "_err_count"}, {16'd0, err_count}, ee);
        check({name, "_ff_idx"},    {16'd0, first_fail_idx}, fi);
        check({name, "_ff_mask"},   {27'd0, first_fail_mask}, {27'd0, fm});
    endtask

    task automatic check_idle_zero(input string name);
        check({name, "_in_ready"},  {31'd0, in_ready}, 32'd0);
        check({name, "_busy"},      {31'd0, busy}, 32'd0);
        check({name, "_done"},      {31'd0, done}, 32'd0);
        check({name, "_pass"},      {31'd0, pass}, 32'd0);
        check({name, "_vec_count"}, {16'd0, vec_count}, 32'd0);
        check({name, "_err_count"}, {16'd0, err_count}, 32'd0);
        check({name, "_ff_idx"},    {16'd0, first_fail_idx}, 32'd0);
        check({name, "_ff_mask"},   {27'd0, first_fail_mask}, 32'd0);
    endtask

    initial begin
        //       idx  a     b     y1    y2    y3    y4    y5    mask
        set_vec(0,  4'h1, 4'h0, 4'h0, 4'h1, 4'h1, 4'hF, 4'hE, 5'b00000);
        set_vec(1,  4'h0, 4'h1, 4'h0, 4'h1, 4'h1, 4'hF, 4'hE, 5'b00000);
        set_vec(2,  4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'hE, 4'hE, 5'b00000);
        set_vec(3,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 5'b00000);
        set_vec(4,  4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'hE, 4'hE, 5'b00100);
        set_vec(5,  4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'hF, 4'hE, 5'b00001);
        set_vec(6,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'b11000);
        set_vec(7,  4'h3, 4'h5, 4'h1, 4'h7, 4'h6, 4'hE, 4'h8, 5'b00000);
        set_vec(8,  4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 5'b00000);
        set_vec(9,  4'hA, 4'h5, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0, 5'b00000);
        set_vec(10, 4'hC, 4'h6, 4'h4, 4'hE, 4'hA, 4'hB, 4'h1, 5'b00000);
        set_vec(11, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0, 4'h7, 4'h7, 5'b00010);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: four correct vectors
        pulse_start(4);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_in_ready", {31'd0, in_ready}, 32'd1);
        seq = '{0, 1, 2, 3};
        stream(-1);
        wait_done();
        check_run("t1");

        // 2: y3 wrong on vector 2
        @(posedge clk); #1;
        pulse_start(4);
        seq = '{0, 1, 4, 3};
        stream(-1);
        wait_done();
        check_run("t2");

        // Single-vector run, mismatch only in the MSB of y2
        @(posedge clk); #1;
        pulse_start(1);
        seq = '{11};
        stream(-1);
        wait_done();
        check_run("msb");

        // 3: back-to-back stream of 8, done two edges after the last transfer
        @(posedge clk); #1;
        pulse_start(8);
        seq = '{7, 8, 9, 10, 0, 1, 2, 3};
        begin
            int rdy_hi = 0;
            foreach (seq[j]) begin
                drive_vec(seq[j]);
                in_valid = 1'b1;
                @(negedge clk);
                if (in_ready) rdy_hi++;
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            check("t3_ready_cycles", rdy_hi, 32'd8);
            @(negedge clk);
            check("t3_ready_after", {31'd0, in_ready}, 32'd0);
            check("t3_done_n1", {31'd0, done}, 32'd0);
            @(negedge clk);
            check("t3_done_n2", {31'd0, done}, 32'd0);
            check("t3_vec_n2", {16'd0, vec_count}, 32'd7);
            @(negedge clk);
            check("t3_done_n3", {31'd0, done}, 32'd1);
        end
        check_run("t3");

        // 6: start pulsed mid-run is ignored; failures on vectors 1 and 3
        @(posedge clk); #1;
        pulse_start(4);
        seq = '{0, 5, 2, 6};
        stream(2);
        wait_done();
        check_run("t6");

        // 4: zero-length run from DONE clears previous errors
        @(posedge clk); #1;
        pulse_start(0);
        check("t4_done", {31'd0, done}, 32'd1);
        check("t4_pass", {31'd0, pass}, 32'd1);
        check("t4_err", {16'd0, err_count}, 32'd0);
        check("t4_vec", {16'd0, vec_count}, 32'd0);
        begin
            int rdy_seen = 0;
            repeat (3) begin
                @(negedge clk);
                if (in_ready) rdy_seen++;
            end
            check("t4_in_ready_never", rdy_seen, 32'd0);
        end

        // 5: asynchronous reset mid-run, then a clean run
        @(posedge clk); #1;
        pulse_start(4);
        seq = '{4, 0};
        stream(-1);
        repeat (2) @(posedge clk);
        #1;
        check("t5_pre_vec", {16'd0, vec_count}, 32'd2);
        check("t5_pre_err", {16'd0, err_count}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check_idle_zero("t5_rst");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        pulse_start(4);
        check("t5_vec_start", {16'd0, vec_count}, 32'd0);
        seq = '{0, 1, 2, 3};
        stream(-1);
        wait_done();
        check_run("t5");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
